// File: rtl/inst_encode_if.sv
// rtl/inst_encode_if.sv - field-bundle input and instruction-word output handshake bundle for inst_encode
interface inst_encode_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_li;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;

   modport slave (
      input  in_valid, in_li, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_err
   );

   modport master (
      output in_valid, in_li, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_err
   );
endinterface

// File: rtl/inst_encode.sv
// rtl/inst_encode.sv - RV32I field-to-word encoder with LI expansion; ENCODE_CHECK_EN builds immediate range checks
module inst_encode (
   input  logic          clk,
   input  logic          reset,
   inst_encode_if.slave  bus
);
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_PEND   = 1'b1;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;

   logic [0:0]  r_state;
   logic        r_out_valid;
   logic [31:0] r_out_inst;
   logic [11:0] r_pend_lo;
   logic [4:0]  r_pend_rd;

   logic        w_in_ready;
   logic        w_accept;
   logic        w_drain;
   logic        w_imm_12;
   logic [19:0] w_li_hi;
   logic        w_li_two;
   logic [31:0] w_word;
   logic [31:0] w_imm;
   logic [4:0]  w_rd;

   assign w_imm      = bus.in_imm;
   assign w_rd       = bus.in_rd;
   assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_drain    = r_out_valid && bus.out_ready;

   // imm fits a signed 12-bit field when bits 31..11 are all copies of the sign
   assign w_imm_12   = (&w_imm[31:11]) || !(|w_imm[31:11]);
   // (imm + 0x800) >> 12, folded so the rounding carry comes straight from imm[11]
   assign w_li_hi    = w_imm[31:12] + {19'd0, w_imm[11]};
   assign w_li_two   = bus.in_li && !w_imm_12 && (w_imm[11:0] != 12'd0);

   always_comb begin
      w_word = {w_imm[11:0], bus.in_rs1, bus.in_funct3, w_rd, bus.in_opcode};
      if (bus.in_li) begin
         if (w_imm_12)
            w_word = {w_imm[11:0], 5'd0, 3'b000, w_rd, OP_IMM};
         else
            w_word = {w_li_hi, w_rd, OP_LUI};
      end else begin
         case (bus.in_opcode)
            OP_JAL:
               w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, bus.in_opcode};
            OP_LUI, OP_AUIPC:
               w_word = {w_imm[31:12], w_rd, bus.in_opcode};
            OP_BRANCH:
               w_word = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         w_imm[4:1], w_imm[11], bus.in_opcode};
            OP_STORE:
               w_word = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         w_imm[4:0], bus.in_opcode};
            OP_OP:
               w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, w_rd, bus.in_opcode};
            default:
               w_word = {w_imm[11:0], bus.in_rs1, bus.in_funct3, w_rd, bus.in_opcode};
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_out_inst  <= 32'd0;
         r_pend_lo   <= 12'd0;
         r_pend_rd   <= 5'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_out_valid <= 1'b1;
                  r_out_inst  <= w_word;
                  if (w_li_two) begin
                     r_state   <= ST_PEND;
                     r_pend_lo <= w_imm[11:0];
                     r_pend_rd <= w_rd;
                  end
               end else if (w_drain) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               // LUI leaves; the held ADDI rd,rd,lo takes its place with out_valid kept high
               if (w_drain) begin
                  r_out_inst <= {r_pend_lo, r_pend_rd, 3'b000, r_pend_rd, OP_IMM};
                  r_state    <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_inst  = r_out_inst;

`ifdef ENCODE_CHECK_EN
   logic r_out_err;
   logic w_err;
   logic w_imm_13;
   logic w_imm_21;

   assign w_imm_13 = (&w_imm[31:12]) || !(|w_imm[31:12]);
   assign w_imm_21 = (&w_imm[31:20]) || !(|w_imm[31:20]);

   always_comb begin
      w_err = 1'b0;
      if (!bus.in_li) begin
         case (bus.in_opcode)
            OP_JAL:          w_err = !w_imm_21 || w_imm[0];
            OP_LUI, OP_AUIPC: w_err = (w_imm[11:0] != 12'd0);
            OP_BRANCH:       w_err = !w_imm_13 || w_imm[0];
            OP_OP:           w_err = 1'b0;
            default:         w_err = !w_imm_12;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_out_err <= 1'b0;
      else if (r_state == ST_IDLE && w_accept)
         r_out_err <= w_err;
      else if (r_state == ST_PEND && w_drain)
         r_out_err <= 1'b0;
   end

   assign bus.out_err = r_out_err;
`else
   assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_encode.sv
// tb/tb_inst_encode.sv - directed and randomized checks of inst_encode against an arithmetic reference model
module tb_inst_encode;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   inst_encode_if bus();
   inst_encode dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   logic [32:0] exp_q[$];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fld(logic [31:0] v, int hi, int lo);
      return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
   endfunction

   function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [31:0] v);
      return ((v & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
   endfunction

   function automatic logic [32:0] model_enc(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                             logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                                             logic [31:0] imm);
      int s;
      logic [31:0] w;
      logic [31:0] regs;
      logic e;
      s = int'(imm);
      regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
      case (op)
         7'h6F: begin
            w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
              | (fld(imm, 19, 12) << 12) | (32'(rd) << 7) | 32'(op);
            e = (s < -1048576) || (s > 1048574) || (imm[0] == 1'b1);
         end
         7'h37, 7'h17: begin
            w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            e = (imm & 32'hFFF) != 32'd0;
         end
         7'h63: begin
            w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | regs
              | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'(op);
            e = (s < -4096) || (s > 4094) || (imm[0] == 1'b1);
         end
         7'h23: begin
            w = (fld(imm, 11, 5) << 25) | regs | (fld(imm, 4, 0) << 7) | 32'(op);
            e = (s < -2048) || (s > 2047);
         end
         7'h33: begin
            w = (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'(op);
            e = 1'b0;
         end
         default: begin
            w = (fld(imm, 11, 0) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
            e = (s < -2048) || (s > 2047);
         end
      endcase
`ifndef ENCODE_CHECK_EN
      e = 1'b0;
`endif
      return {e, w};
   endfunction

   task automatic model_push(logic li, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                             logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
      int s;
      logic [31:0] hi;
      s = int'(imm);
      if (!li) begin
         exp_q.push_back(model_enc(op, rd, rs1, rs2, f3, f7, imm));
      end else if (s >= -2048 && s <= 2047) begin
         exp_q.push_back({1'b0, addi(rd, 5'd0, imm)});
      end else begin
         hi = (imm + 32'h800) & 32'hFFFFF000;
         exp_q.push_back({1'b0, hi | (32'(rd) << 7) | 32'h37});
         if ((imm & 32'hFFF) != 32'd0)
            exp_q.push_back({1'b0, addi(rd, rd, imm)});
      end
   endtask

   task automatic drive(logic li, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                        logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
      bus.in_li     = li;
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_imm    = imm;
   endtask

   task automatic one_shot(string tag, logic li, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                           logic [4:0] rs2, logic [2:0] f3, logic [31:0] imm,
                           logic [31:0] exp_w, logic exp_e);
      @(negedge clk);
      drive(li, op, rd, rs1, rs2, f3, 7'd0, imm);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1 chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".inst"}, bus.out_inst, exp_w);
      chk({tag, ".err"}, 32'(bus.out_err), 32'(exp_e));
   endtask

   logic [6:0] ops[9] = '{7'h6F, 7'h37, 7'h17, 7'h63, 7'h23, 7'h33, 7'h13, 7'h03, 7'h67};
   int bnd[12] = '{-2048, 2047, 2048, -2049, 4094, 4095, -4096, -4098,
                   1048574, -1048576, 1048576, 4096};

   initial begin
      logic        big_err;
      logic        r_li;
      logic [6:0]  r_op;
      logic [31:0] r_imm;
      int          cyc;

`ifdef ENCODE_CHECK_EN
      big_err = 1'b1;
`else
      big_err = 1'b0;
`endif
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

      #1 reset = 1'b1;
      #1;
      chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst.out_inst", bus.out_inst, 32'd0);
      chk("rst.out_err", 32'(bus.out_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      #1 chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

      one_shot("addi", 1'b0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd5, 32'h00510093, 1'b0);
      one_shot("sw", 1'b0, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 32'd8, 32'h00512423, 1'b0);
      one_shot("jal", 1'b0, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h001000EF, 1'b0);
      one_shot("addi4096", 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096, 32'h00000093, big_err);
      one_shot("li1000", 1'b1, 7'h00, 5'd3, 5'd0, 5'd0, 3'd0, 32'h1000, 32'h000011B7, 1'b0);
      chk("li1000.in_ready", 32'(bus.in_ready), 32'd1);
      one_shot("lim1", 1'b1, 7'h00, 5'd3, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 32'hFFF00193, 1'b0);

      // two-word LI held by a stalled consumer
      one_shot("li2", 1'b1, 7'h00, 5'd3, 5'd0, 5'd0, 3'd0, 32'h12345FFF, 32'h123461B7, 1'b0);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk("li2.hold.inst", bus.out_inst, 32'h123461B7);
         chk("li2.hold.valid", 32'(bus.out_valid), 32'd1);
         chk("li2.hold.in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk) bus.out_ready = 1'b1;
      #1 chk("li2.pend.in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1 chk("li2.second", bus.out_inst, 32'hFFF18193);
      chk("li2.second.valid", 32'(bus.out_valid), 32'd1);
      chk("li2.second.in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 chk("li2.drained", 32'(bus.out_valid), 32'd0);

      // reset while the ADDI half is pending
      one_shot("lirst", 1'b1, 7'h00, 5'd4, 5'd0, 5'd0, 3'd0, 32'h12345678, 32'h12345237, 1'b0);
      bus.out_ready = 1'b0;
      #2 reset = 1'b1;
      #1 chk("lirst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("lirst.out_inst", bus.out_inst, 32'd0);
      @(negedge clk) reset = 1'b0;
      bus.out_ready = 1'b1;
      #1 chk("lirst.in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk("lirst.no_addi", 32'(bus.out_valid), 32'd0);
      end

      for (int i = 1; i < 5; i++)
         one_shot("b2b", 1'b0, 7'h13, 5'(i), 5'(i), 5'd0, 3'd0, 32'(i * 3),
                  addi(5'(i), 5'(i), 32'(i * 3)), 1'b0);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);

      // randomized traffic against the queue model
      exp_q.delete();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         r_li = ($urandom_range(0, 3) == 0);
         r_op = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 9) == 0) r_op = 7'($urandom);
         case ($urandom_range(0, 3))
            0: r_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: r_imm = 32'(bnd[$urandom_range(0, 11)]);
            2: r_imm = $urandom & 32'hFFFFF000;
            default: r_imm = $urandom;
         endcase
         drive(r_li, r_op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
               7'($urandom), r_imm);
         #1;
         chk("rnd.out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
         chk("rnd.in_ready", 32'(bus.in_ready),
             32'((exp_q.size() < 2) && (exp_q.size() == 0 || bus.out_ready)));
         if (exp_q.size() > 0) begin
            chk("rnd.inst", bus.out_inst, exp_q[0][31:0]);
            chk("rnd.err", 32'(bus.out_err), 32'(exp_q[0][32]));
         end
         if (bus.out_valid && bus.out_ready && exp_q.size() > 0)
            void'(exp_q.pop_front());
         if (bus.in_valid && bus.in_ready)
            model_push(r_li, r_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3,
                       bus.in_funct7, r_imm);
      end

      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 10) begin
         #1;
         chk("drain.inst", bus.out_inst, exp_q[0][31:0]);
         if (bus.out_valid) void'(exp_q.pop_front());
         @(negedge clk);
         cyc++;
      end
      #1 chk("drain.empty", 32'(exp_q.size()), 32'd0);
      chk("drain.out_valid", 32'(bus.out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_encode.md
Name: inst_encode

Overview:
- RV32I instruction encoder: accepts decoded instruction fields and emits packed 32-bit instruction words; it is the inverse of the instruction decoder.
- Used by the debug/boot program injector to build instruction words that are fed into the fetch path.
- Supports an LI pseudo-op that expands into ADDI, LUI, or LUI+ADDI.
- Valid/ready handshake on both sides; output is registered.

Parameters:
- None.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  block accepts bundle this cycle
- in_li  in  1  treat bundle as LI rd,imm pseudo-op; in_opcode/rs1/rs2/funct3/funct7 ignored
- in_opcode  in  7  major opcode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7
- in_imm  in  32  immediate as a signed byte/offset value (not pre-shifted except U: full 32-bit value)
- out_valid  out  1  out_inst valid
- out_ready  in  1  consumer accepts word
- out_inst  out  32  encoded instruction
- out_err  out  1  immediate not representable in the selected format; qualified by out_valid

Behaviour:
- Reset (async, immediate): out_valid=0, out_inst=0, out_err=0, state=IDLE. in_ready=1 once reset is released.
- Handshake rules:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - out_inst and out_err hold stable while out_valid && !out_ready.
- Latency: bundle accepted at edge N -> word on out_inst with out_valid=1 after edge N.
- Full throughput of 1 word/cycle for non-LI bundles.
- Format select by opcode:
  - JAL 1101111 -> J
  - LUI 0110111 / AUIPC 0010111 -> U
  - BRANCH 1100011 -> B
  - STORE 0100011 -> S
  - OP 0110011 -> R (funct7, rs2, rs1, funct3, rd)
  - all other opcodes -> I (imm[11:0], rs1, funct3, rd)
- Field packing:
  - U packs in_imm[31:12].
  - B/J pack imm[12:1] / imm[20:1]; imm[0] is dropped.
  - Out-of-range fields are truncated.
- Range checks (raise out_err):
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094] or odd.
  - J: imm outside [-2^20, 2^20-2] or odd.
  - U: imm[11:0] != 0.
  - R: never errors.
- LI expansion:
  - imm in [-2048, 2047]: single word ADDI rd,x0,imm.
  - Otherwise hi = (imm + 32'h800)[31:12] (wraps mod 2^32), lo = imm[11:0].
  - First word is LUI rd,hi.
  - If lo != 0, the block enters PEND and holds lo/rd.
  - On the first word's output transfer, it loads ADDI rd,rd,lo, then returns to IDLE.
  - in_ready=0 throughout PEND. LI never sets out_err.
- State machine:
  - IDLE -> PEND on LI acceptance that needs two words.
  - PEND -> IDLE when the second word loads.
- Boundary cases:
  - Simultaneous output drain and new input acceptance in IDLE: the new word replaces the old with no bubble.
  - Reset in PEND discards the pending ADDI.
  - rd=0 is encoded as given, with no special-casing.

Optional Feature:
- Macro: ENCODE_CHECK_EN.
- Defined: range checks drive out_err as specified.
- Undefined: out_err is tied to 0 and no check logic is built; encoding is otherwise identical.

Test Plan:
- ADDI x1,x2,5 (opcode 0010011, rd=1, rs1=2, f3=0, imm=5) -> out_inst=0x00510093 one cycle after accept, out_err=0.
- SW x5,8(x2) (opcode 0100011, f3=010, rs1=2, rs2=5, imm=8) -> 0x00512423. JAL x1,+2048 -> 0x001000EF.
- LI x3,0x12345FFF with out_ready=0 for 3 cycles:
  - 0x123461B7 held stable; then 0xFFF18193.
  - in_ready=0 until the second word is loaded.
- LI x3,0x1000 -> single word 0x000011B7, in_ready stays 1. LI x3,-1 -> single word 0xFFF00193.
- ADDI x1,x0,4096 -> 0x00000093 with out_err=1 (ENCODE_CHECK_EN defined) or out_err=0 (undefined).
- Reset asserted in PEND mid-LI -> out_valid=0 immediately, no ADDI emitted, in_ready=1 after reset release; back-to-back bundles with out_ready=1 -> one word per cycle.
